// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

   // Read-mode selector values for FWFT_MODE
   localparam string FWFT_TRUE  = "TRUE";
   localparam string FWFT_FALSE = "FALSE";

   // Width needed to hold a word count of 0..depth
   function automatic int unsigned cnt_width(input int unsigned depth);
      return 32'($clog2(depth + 1));
   endfunction

   // Width needed to address 0..depth-1 (at least one bit)
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? 32'($clog2(depth)) : 32'd1;
   endfunction

   // Pointer increment that wraps at depth, no power-of-two assumption
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr + 1 >= depth) ? 32'd0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
module fifo_ram_sdp #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 3,
   parameter string       RAM_STYLE = "distributed"
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // Block-style memories only offer registered reads, which the FIFO cannot use
   if (RAM_STYLE == "block" || RAM_STYLE == "ultra") begin : g_chk_style
      $error("fifo_ram_sdp: RAM_STYLE must support asynchronous read");
   end

   (* ram_style = RAM_STYLE *) logic [DATA_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read port
   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_single_clock_flags.sv
// Single-clock RAM FIFO with arbitrary depth, threshold flags, sticky errors,
// synchronous flush and optional first-word-fall-through read.
module fifo_single_clock_flags
   import fifo_pkg::*;
#(
   parameter string       FWFT_MODE = "FALSE",
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned AF_LEVEL  = DEPTH - 1,
   parameter int unsigned AE_LEVEL  = 1,
   parameter string       RAM_STYLE = "distributed",
   parameter int unsigned CNT_W     = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              flush,
   input  logic              w_req,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_req,
   output logic [DATA_W-1:0] r_data,
   output logic [CNT_W-1:0]  cnt,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned PTR_W   = ptr_width(DEPTH);
   localparam bit          IS_FWFT = (FWFT_MODE == FWFT_TRUE);

   // Elaboration-time parameter sanity
   if (DEPTH < 2) begin : g_chk_depth
      $error("fifo_single_clock_flags: DEPTH must be >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
      $error("fifo_single_clock_flags: AF_LEVEL must be in 1..DEPTH");
   end
   if (AE_LEVEL > DEPTH - 1) begin : g_chk_ae
      $error("fifo_single_clock_flags: AE_LEVEL must be in 0..DEPTH-1");
   end
   if (FWFT_MODE != FWFT_TRUE && FWFT_MODE != FWFT_FALSE) begin : g_chk_mode
      $error("fifo_single_clock_flags: FWFT_MODE must be TRUE or FALSE");
   end
   if (CNT_W != cnt_width(DEPTH)) begin : g_chk_cntw
      $error("fifo_single_clock_flags: CNT_W is derived and must not be overridden");
   end

   logic              wa;
   logic              ra;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr_inc;
   logic [PTR_W-1:0]  rd_ptr_inc;
   logic [PTR_W-1:0]  wr_ptr_nxt;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic [PTR_W-1:0]  ram_raddr;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              overflow_nxt;
   logic              underflow_nxt;
   logic [DATA_W-1:0] r_data_nxt;
   logic [DATA_W-1:0] ram_rdata;

   // Status flags straight from the registered count
   assign empty        = (cnt == '0);
   assign full         = (cnt == CNT_W'(DEPTH));
   assign almost_full  = (cnt >= CNT_W'(AF_LEVEL));
   assign almost_empty = (cnt <= CNT_W'(AE_LEVEL));

   // A write into a full FIFO is still accepted when a pop frees the slot
   assign wa = w_req & (~full | r_req);
   assign ra = r_req & ~empty;

   // Wrapped pointer successors
   always_comb begin
      wr_ptr_inc = PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
      rd_ptr_inc = PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
   end

   // FWFT prefetches the word behind the head; normal mode reads the head itself
   assign ram_raddr = IS_FWFT ? rd_ptr_inc : rd_ptr;

   fifo_ram_sdp #(
      .DEPTH     (DEPTH),
      .DATA_W    (DATA_W),
      .ADDR_W    (PTR_W),
      .RAM_STYLE (RAM_STYLE)
   ) u_ram (
      .clk   (clk),
      .we    (wa & ~flush),
      .waddr (wr_ptr),
      .wdata (w_data),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Next-state for pointers, count, error flags and the output register
   always_comb begin
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      cnt_nxt       = cnt;
      overflow_nxt  = overflow;
      underflow_nxt = underflow;
      r_data_nxt    = r_data;

      if (flush) begin
         wr_ptr_nxt    = '0;
         rd_ptr_nxt    = '0;
         cnt_nxt       = '0;
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end else begin
         if (wa) begin
            wr_ptr_nxt = wr_ptr_inc;
         end
         if (ra) begin
            rd_ptr_nxt = rd_ptr_inc;
         end

         if (wa && !ra) begin
            cnt_nxt = cnt + CNT_W'(1);
         end else if (ra && !wa) begin
            cnt_nxt = cnt - CNT_W'(1);
         end

         if (w_req && !wa) begin
            overflow_nxt = 1'b1;
         end
         if (r_req && !ra) begin
            underflow_nxt = 1'b1;
         end

         if (IS_FWFT) begin
            // Bypass when the new word becomes the head, else advance to the next stored word
            if (wa && (empty || (ra && cnt == CNT_W'(1)))) begin
               r_data_nxt = w_data;
            end else if (ra && cnt >= CNT_W'(2)) begin
               r_data_nxt = ram_rdata;
            end
         end else if (ra) begin
            r_data_nxt = ram_rdata;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         r_data    <= '0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         cnt       <= cnt_nxt;
         overflow  <= overflow_nxt;
         underflow <= underflow_nxt;
         r_data    <= r_data_nxt;
      end
   end

endmodule
